popcnt_rr_scheduler: RTL and testbench
======================================

// Module: popcnt_rr_scheduler
//
// PURPOSE
//   Shares one bit_population_counter instance among NUM_REQ requesters.
//   Round-robin grant, one request per cycle. The issued word goes to the counter.
//   The requester index is kept in an in-order tag FIFO.
//   Each counter result is returned to its requester as rsp_data_o/rsp_id_o.
//   Sits between client channels and the shared counter; one clock domain.
//
// PARAMETERS
//   NUM_REQ    4   number of requester channels (2..16)
//   WIDTH      16  data word width, equal to the counter's WIDTH
//   TAG_DEPTH  8   max in-flight words; power of 2, at least counter latency + 2
//
// PORTS
//   clk_i        in   1                           clock
//   srst_i       in   1                           synchronous reset, active-high
//   req_data_i   in   NUM_REQ x WIDTH             per-requester input word
//   req_val_i    in   NUM_REQ                     per-requester valid
//   req_ready_o  out  NUM_REQ                     per-requester ready (one-hot or zero)
//   cnt_data_o   out  WIDTH                       word to counter data_i
//   cnt_val_o    out  1                           to counter data_val_i
//   cnt_data_i   in   $clog2(WIDTH)+1             from counter data_o
//   cnt_val_i    in   1                           from counter data_val_o
//   rsp_data_o   out  $clog2(WIDTH)+1             population count result
//   rsp_id_o     out  $clog2(NUM_REQ)             owning requester index
//   rsp_val_o    out  1                           result valid (single-cycle pulse, no backpressure)
//   err_o        out  1                           pulse: counter result with empty tag FIFO
//
// BEHAVIOUR
//   - Reset (srst_i=1): rr pointer=0, FIFO empty.
//     cnt_val_o, rsp_val_o, err_o, req_ready_o = 0; data outputs = 0.
//   - Arbitration (combinational):
//     - Search req_val_i starting at the pointer, wrapping NUM_REQ-1 -> 0.
//     - First hit k gets req_ready_o[k]=1, but only if the FIFO is not full and srst_i=0.
//     - Transfer on req_val_i[k] & req_ready_o[k].
//     - Pointer then becomes (k+1) mod NUM_REQ; unchanged if there is no transfer.
//   - Full FIFO blocks all grants, even if a pop occurs in the same cycle (no full bypass).
//   - Issue: a transfer in cycle t gives cnt_data_o=req_data_i[k], cnt_val_o=1 at t+1.
//     - Tag k is pushed in cycle t.
//     - cnt_data_o holds its last value when cnt_val_o=0.
//   - Return: cnt_val_i in cycle t pops the FIFO head h.
//     - rsp_data_o=cnt_data_i, rsp_id_o=h, rsp_val_o=1 at t+1.
//     - The counter is order-preserving, so there is no reordering.
//   - Simultaneous push and pop in the same cycle: both occur; occupancy is unchanged.
//   - cnt_val_i with FIFO empty: result dropped; err_o=1 at t+1; rsp_val_o stays 0.
//   - Reset mid-operation: in-flight tags are discarded.
//     - Counter results arriving after reset deasserts hit an empty FIFO and raise err_o.
//     - The integrator resets the counter together with this block.
//   - Requester end-to-end latency = 1 + counter latency + 1 cycles.
//
// CONFIGURATION
//   POPCNT_SCHED_STATS_EN
//   - Defined: adds output grant_cnt_o (NUM_REQ x 16).
//     - Per-requester count of accepted words; saturates at 16'hFFFF.
//     - Cleared by srst_i.
//   - Undefined: the port and its counters are absent; all other behaviour is identical.
//
// STRUCTURE
//   - Package popcnt_sched_pkg:
//     - typedef req_id_t (logic [$clog2(NUM_REQ)-1:0]) for the parameter defaults;
//     - function rr_pick (rotating priority encoder);
//     - localparam STAT_W=16.
//   - Sub-module popcnt_tag_fifo:
//     - synchronous FIFO of req_id_t, TAG_DEPTH deep;
//     - push/pop/full/empty; pointers one bit wider than the address.
//   - The top holds the arbiter, issue register and response register.
//
// TESTING
//   1. Reset then idle: all req_val_i=0 for 20 cycles
//      -> cnt_val_o, rsp_val_o, err_o stay 0.
//   2. Single requester: req 2 sends 16'hFFFF, then 16'h0001
//      -> rsp_id_o=2, rsp_data_o=16 then 1, in order.
//   3. All 4 requesters valid continuously, pointer 0
//      -> grant order 0,1,2,3,0,...
//      -> each rsp_id_o matches its issuer; 16'h00F0 yields 4.
//   4. Stalled counter model (cnt_val_i held 0)
//      -> exactly TAG_DEPTH=8 transfers, then req_ready_o=0 until the first cnt_val_i.
//   5. Inject cnt_val_i with FIFO empty
//      -> err_o pulses 1 cycle later, rsp_val_o=0.
//      -> Reset with 3 words in flight: FIFO empty after reset, err_o on each late result.
//   6. With POPCNT_SCHED_STATS_EN: 5 words from req 1
//      -> grant_cnt_o[1]=5, others 0; counter saturates at 16'hFFFF.

Source files
------------

// File: rtl/popcnt_sched_pkg.sv
// Shared types, limits and the rotating priority encoder used by popcnt_rr_scheduler.
package popcnt_sched_pkg;

  localparam int NUM_REQ_DFLT = 4;
  localparam int MAX_REQ      = 16;
  localparam int STAT_W       = 16;

  typedef logic [$clog2(NUM_REQ_DFLT)-1:0] req_id_t;
  typedef logic [$clog2(MAX_REQ)-1:0]      rr_idx_t;

  typedef struct packed {
    logic    hit;
    rr_idx_t idx;
  } rr_pick_t;

  // First set bit of val[n-1:0] at or after ptr, wrapping n-1 -> 0.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] val,
                                       input rr_idx_t            ptr,
                                       input int unsigned        n);
    rr_pick_t    res;
    int unsigned idx;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !res.hit && val[rr_idx_t'(idx)]) begin
        res.hit = 1'b1;
        res.idx = rr_idx_t'(idx);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/popcnt_tag_fifo.sv
// In-order FIFO of requester tags; pointers carry an extra wrap bit to tell full from empty.
module popcnt_tag_fifo
  import popcnt_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ID_W  = $bits(req_id_t)
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [ID_W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; entries are only read after a push, so the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_id_i;
  end

endmodule

// File: rtl/popcnt_rr_scheduler.sv
// Round-robin front end sharing one population counter among NUM_REQ requesters.
// Optional per-requester grant counters are built when POPCNT_SCHED_STATS_EN is defined.
module popcnt_rr_scheduler
  import popcnt_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic                               clk_i,
  input  logic                               srst_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]      req_data_i,
  input  logic [NUM_REQ-1:0]                 req_val_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [WIDTH-1:0]                   cnt_data_o,
  output logic                               cnt_val_o,
  input  logic [$clog2(WIDTH):0]             cnt_data_i,
  input  logic                               cnt_val_i,
  output logic [$clog2(WIDTH):0]             rsp_data_o,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id_o,
  output logic                               rsp_val_o,
  output logic                               err_o
`ifdef POPCNT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_W-1:0]     grant_cnt_o
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW   = $clog2(WIDTH) + 1;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  rr_pick_t         pick;
  logic [ID_W-1:0]  grant_id;
  logic             xfer, pop;
  logic             fifo_full, fifo_empty;
  logic [ID_W-1:0]  head_id;

  logic             cnt_val_q, cnt_val_d;
  logic [WIDTH-1:0] cnt_data_q, cnt_data_d;
  logic             rsp_val_q, rsp_val_d;
  logic [CW-1:0]    rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             err_q, err_d;

  // A full tag FIFO blocks grants even when a pop is under way this cycle.
  always_comb begin
    pick        = rr_pick(MAX_REQ'(req_val_i), rr_idx_t'(rr_ptr_q), NUM_REQ);
    grant_id    = ID_W'(pick.idx);
    req_ready_o = '0;
    if (pick.hit && !fifo_full && !srst_i) req_ready_o[grant_id] = 1'b1;
    xfer        = |(req_ready_o & req_val_i);
    rr_ptr_d    = rr_ptr_q;
    if (xfer) rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  assign pop = cnt_val_i & ~fifo_empty;

  popcnt_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .ID_W  (ID_W)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .push_i    (xfer),
    .push_id_i (grant_id),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head_id)
  );

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_val_d  = xfer;
    cnt_data_d = cnt_data_q;
    rsp_val_d  = pop;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    err_d      = cnt_val_i & fifo_empty;
    if (xfer) cnt_data_d = req_data_i[grant_id];
    if (pop) begin
      rsp_data_d = cnt_data_i;
      rsp_id_d   = head_id;
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values together.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rr_ptr_q   <= '0;
      cnt_val_q  <= 1'b0;
      cnt_data_q <= '0;
      rsp_val_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cnt_val_q  <= cnt_val_d;
      cnt_data_q <= cnt_data_d;
      rsp_val_q  <= rsp_val_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      err_q      <= err_d;
    end
  end

  assign cnt_val_o  = cnt_val_q;
  assign cnt_data_o = cnt_data_q;
  assign rsp_val_o  = rsp_val_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_id_o   = rsp_id_q;
  assign err_o      = err_q;

`ifdef POPCNT_SCHED_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] grant_cnt_q, grant_cnt_d;

  // Saturating per-requester count of accepted words.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready_o[i] && req_val_i[i] && grant_cnt_q[i] != '1)
        grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) grant_cnt_q <= '0;
    else        grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_popcnt_rr_scheduler.sv
// Self-checking bench for popcnt_rr_scheduler: vector table, directed corner cases and a random run
// against a queue-based scoreboard; a bench-side counter model closes the cnt_* loop.
module tb_popcnt_rr_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 16;
  localparam int TAG_DEPTH = 8;
  localparam int ID_W      = 2;
  localparam int CW        = 5;
  localparam int LAT       = 2;

  logic                          clk_i = 1'b0;
  logic                          srst_i;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_val_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [WIDTH-1:0]              cnt_data_o;
  logic                          cnt_val_o;
  logic [CW-1:0]                 cnt_data_i;
  logic                          cnt_val_i;
  logic [CW-1:0]                 rsp_data_o;
  logic [ID_W-1:0]               rsp_id_o;
  logic                          rsp_val_o;
  logic                          err_o;
`ifdef POPCNT_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0]      grant_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  popcnt_rr_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .req_data_i  (req_data_i),
    .req_val_i   (req_val_i),
    .req_ready_o (req_ready_o),
    .cnt_data_o  (cnt_data_o),
    .cnt_val_o   (cnt_val_o),
    .cnt_data_i  (cnt_data_i),
    .cnt_val_i   (cnt_val_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_val_o   (rsp_val_o),
    .err_o       (err_o)
`ifdef POPCNT_SCHED_STATS_EN
    ,
    .grant_cnt_o (grant_cnt_o)
`endif
  );

  typedef struct { int rdy; logic [CW-1:0] cnt; } cq_t;
  typedef struct { int id; int cnt; } rsp_t;
  typedef struct {
    logic [NUM_REQ-1:0] val;
    logic [WIDTH-1:0]   data;
    logic [NUM_REQ-1:0] ready;
    int                 cnt;
    int                 id;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // stimulus controls, applied to the DUT at each falling edge
  logic                          tb_srst = 1'b1;
  logic [NUM_REQ-1:0]            tb_val  = '0;
  logic [NUM_REQ-1:0][WIDTH-1:0] tb_data = '0;
  logic                          tb_stall = 1'b0;
  logic                          tb_inj   = 1'b0;
  logic [CW-1:0]                 tb_inj_data = '0;

  // counter model, scoreboard and observations
  cq_t   cq[$];
  int    tagq[$];
  rsp_t  obs_rsp[$];
  int    m_ptr = 0;
  int    gcnt[NUM_REQ];
  logic  e_cnt_val = 0, e_rsp_val = 0, e_err = 0;
  logic [WIDTH-1:0] e_cnt_data = '0;
  int    e_rsp_id = 0, e_rsp_data = 0;
  logic [NUM_REQ-1:0] last_ready;
  logic  s_err, s_rsp_val;
  int    n_err = 0, n_cval = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic cycle();
    logic [NUM_REQ-1:0] exp_ready;
    int k;
    @(negedge clk_i);
    cyc++;
    check("cnt_val", cnt_val_o, e_cnt_val);
    check("cnt_data", cnt_data_o, e_cnt_data);
    check("rsp_val", rsp_val_o, e_rsp_val);
    if (e_rsp_val) begin
      check("rsp_id", rsp_id_o, e_rsp_id);
      check("rsp_data", rsp_data_o, e_rsp_data);
    end
    check("err", err_o, e_err);
`ifdef POPCNT_SCHED_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) check($sformatf("grant_cnt%0d", i), grant_cnt_o[i], gcnt[i]);
`endif
    s_err     = err_o;
    s_rsp_val = rsp_val_o;
    if (rsp_val_o) obs_rsp.push_back('{int'(rsp_id_o), int'(rsp_data_o)});
    if (err_o) n_err++;
    if (cnt_val_o) begin
      n_cval++;
      cq.push_back('{cyc + LAT, CW'($countones(cnt_data_o))});
    end
    srst_i     = tb_srst;
    req_val_i  = tb_val;
    req_data_i = tb_data;
    if (tb_inj) begin
      cnt_val_i  = 1'b1;
      cnt_data_i = tb_inj_data;
    end else if (!tb_stall && cq.size() > 0 && cq[0].rdy <= cyc) begin
      cnt_val_i  = 1'b1;
      cnt_data_i = cq[0].cnt;
      cq.delete(0);
    end else begin
      cnt_val_i = 1'b0;
    end
    #1;
    exp_ready = '0;
    k = -1;
    if (!srst_i) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (k < 0 && req_val_i[(m_ptr + i) % NUM_REQ]) k = (m_ptr + i) % NUM_REQ;
      if (k >= 0 && tagq.size() < TAG_DEPTH) exp_ready[k] = 1'b1;
    end
    check("ready", req_ready_o, exp_ready);
    last_ready = req_ready_o;
    if (srst_i) begin
      tagq.delete();
      m_ptr = 0;
      e_cnt_val = 0; e_cnt_data = '0; e_rsp_val = 0; e_err = 0;
      foreach (gcnt[i]) gcnt[i] = 0;
    end else begin
      if (cnt_val_i && tagq.size() > 0) begin
        e_rsp_val  = 1;
        e_rsp_id   = tagq[0];
        e_rsp_data = int'(cnt_data_i);
        e_err      = 0;
        tagq.delete(0);
      end else begin
        e_rsp_val = 0;
        e_err     = cnt_val_i;
      end
      if (exp_ready != '0) begin
        tagq.push_back(k);
        m_ptr      = (k + 1) % NUM_REQ;
        e_cnt_val  = 1;
        e_cnt_data = req_data_i[k];
        if (gcnt[k] < 16'hFFFF) gcnt[k]++;
      end else begin
        e_cnt_val = 0;
      end
    end
  endtask

  task automatic do_reset(input bit keep_counter);
    tb_srst = 1'b1;
    tb_val  = '0;
    cycle();
    cycle();
    tb_srst = 1'b0;
    if (!keep_counter) cq.delete();
    obs_rsp.delete();
    n_err  = 0;
    n_cval = 0;
  endtask

  task automatic drain();
    tb_val   = '0;
    tb_stall = 1'b0;
    for (int i = 0; i < 60 && (tagq.size() > 0 || cq.size() > 0); i++) cycle();
    cycle();
    cycle();
    check("drain_bound", tagq.size() + cq.size(), 0);
  endtask

  task automatic expect_rsp(input string name, input int id, input int cnt);
    check({name, "_present"}, obs_rsp.size() > 0, 1);
    if (obs_rsp.size() > 0) begin
      check({name, "_id"}, obs_rsp[0].id, id);
      check({name, "_cnt"}, obs_rsp[0].cnt, cnt);
      obs_rsp.delete(0);
    end
  endtask

  initial begin
    vec_t vecs[10];
    logic [WIDTH-1:0] t3_data[4];
    int t3_cnt[4];
    int n_x;

    vecs[0] = '{4'b0000, 16'h1234, 4'b0000,  0, -1};
    vecs[1] = '{4'b0100, 16'hFFFF, 4'b0100, 16,  2};
    vecs[2] = '{4'b0111, 16'h0001, 4'b0001,  1,  0};
    vecs[3] = '{4'b1001, 16'h00F0, 4'b1000,  4,  3};
    vecs[4] = '{4'b1111, 16'h0000, 4'b0001,  0,  0};
    vecs[5] = '{4'b0001, 16'hA5A5, 4'b0001,  8,  0};
    vecs[6] = '{4'b1110, 16'h8000, 4'b0010,  1,  1};
    vecs[7] = '{4'b0010, 16'h7FFF, 4'b0010, 15,  1};
    vecs[8] = '{4'b1100, 16'h0F0F, 4'b0100,  8,  2};
    vecs[9] = '{4'b1000, 16'h3333, 4'b1000,  8,  3};
    t3_data = '{16'h00F0, 16'h0003, 16'h8001, 16'hFFFE};
    t3_cnt  = '{4, 2, 2, 15};
    foreach (gcnt[i]) gcnt[i] = 0;

    srst_i = 1'b1; req_val_i = '0; req_data_i = '0; cnt_val_i = 1'b0; cnt_data_i = '0;
    @(posedge clk_i);

    // reset then idle
    do_reset(0);
    repeat (20) cycle();
    check("idle_cnt_val", n_cval, 0);
    check("idle_rsp", obs_rsp.size(), 0);
    check("idle_err", n_err, 0);

    // table of grant decisions from a fresh pointer
    do_reset(0);
    for (int i = 0; i < 10; i++) begin
      tb_val = vecs[i].val;
      for (int r = 0; r < NUM_REQ; r++) tb_data[r] = vecs[i].data;
      cycle();
      check($sformatf("vec%0d_ready", i), last_ready, vecs[i].ready);
    end
    drain();
    for (int i = 0; i < 10; i++)
      if (vecs[i].id >= 0) expect_rsp($sformatf("vec%0d_rsp", i), vecs[i].id, vecs[i].cnt);

    // single requester, two words in order
    do_reset(0);
    tb_val = 4'b0100;
    tb_data[2] = 16'hFFFF; cycle();
    tb_data[2] = 16'h0001; cycle();
    drain();
    check("t2_count", obs_rsp.size(), 2);
    expect_rsp("t2_first", 2, 16);
    expect_rsp("t2_second", 2, 1);

    // all requesters valid: strict rotation
    do_reset(0);
    tb_val = 4'b1111;
    for (int r = 0; r < NUM_REQ; r++) tb_data[r] = t3_data[r];
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("t3_grant%0d", i), last_ready, 32'(1) << (i % 4));
    end
    drain();
    for (int i = 0; i < 8; i++) expect_rsp($sformatf("t3_rsp%0d", i), i % 4, t3_cnt[i % 4]);

    // stalled counter fills the tag FIFO
    do_reset(0);
    tb_stall = 1'b1;
    tb_val = 4'b1111;
    n_x = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (|(last_ready & tb_val)) n_x++;
    end
    check("t4_transfers", n_x, TAG_DEPTH);
    check("t4_blocked", last_ready, 0);
    tb_stall = 1'b0;
    cycle();
    check("t4_no_bypass", last_ready, 0);
    cycle();
    check("t4_resume", last_ready != 0, 1);
    drain();
    check("t4_rsp_count", obs_rsp.size(), TAG_DEPTH + 1);

    // result with empty tag FIFO
    do_reset(0);
    cycle(); cycle();
    tb_inj = 1'b1; tb_inj_data = 5'd5;
    cycle();
    tb_inj = 1'b0;
    cycle();
    check("t5_err_pulse", s_err, 1);
    check("t5_no_rsp", s_rsp_val, 0);
    cycle();
    check("t5_err_clear", s_err, 0);

    // reset with three words in flight
    do_reset(0);
    tb_stall = 1'b1;
    tb_val = 4'b0001;
    tb_data[0] = 16'h0101;
    repeat (3) cycle();
    tb_val = '0;
    repeat (2) cycle();
    check("t5_inflight", cq.size(), 3);
    do_reset(1);
    tb_stall = 1'b0;
    repeat (8) cycle();
    check("t5_late_err", n_err, 3);
    check("t5_late_rsp", obs_rsp.size(), 0);

    // random traffic with bursty counter stalls
    do_reset(0);
    for (int i = 0; i < 400; i++) begin
      tb_val = NUM_REQ'($urandom);
      for (int r = 0; r < NUM_REQ; r++) tb_data[r] = WIDTH'($urandom);
      if ($urandom_range(0, 9) == 0) tb_stall = ~tb_stall;
      cycle();
    end
    drain();

`ifdef POPCNT_SCHED_STATS_EN
    do_reset(0);
    tb_val = 4'b0010;
    repeat (5) cycle();
    tb_val = '0;
    cycle();
    for (int i = 0; i < NUM_REQ; i++)
      check($sformatf("t6_stat%0d", i), grant_cnt_o[i], (i == 1) ? 5 : 0);
    tb_val = 4'b0010;
    repeat (65540) cycle();
    drain();
    check("t6_saturate", grant_cnt_o[1], 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
